// File: rtl/lut_table_dump.sv
// Truth-table reader for a LogicNets neuron. It walks every input code, packs the
// returned entries LSB-first into stream words, and keeps a running 16-bit entry sum.
module lut_table_dump #(
   parameter int IN_BITS     = 8,
   parameter int OUT_BITS    = 2,
   parameter int WORD_W      = 32,
   parameter int LUT_LATENCY = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [IN_BITS-1:0]  lut_in,
   input  logic [OUT_BITS-1:0] lut_out,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [WORD_W-1:0]   m_data,
   output logic                m_last,
   output logic [15:0]         sum
);
   localparam int E      = WORD_W / OUT_BITS;
   localparam int NWORDS = (1 << IN_BITS) / E;
   localparam int KW     = (E > 1) ? $clog2(E) : 1;
   localparam int CW     = $clog2(E + 1);
   localparam int WW     = $clog2(NWORDS + 1);
   localparam logic [KW-1:0] SLOT_LAST = KW'(E - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(E);
   localparam logic [CW-1:0] CNT_LAST  = CW'(E - 1);
   localparam logic [WW-1:0] WORD_LAST = WW'(NWORDS - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

   state_t              state_q, state_d;
   logic [KW-1:0]       slot_q, slot_d;
   logic [IN_BITS-1:0]  lut_in_d;
   logic                done_d;
   logic                clear;
   logic                issue_v;
   logic                cap_v;
   logic [KW-1:0]       cap_k;
   logic [WORD_W-1:0]   pack_q, pack_word;
   logic [CW-1:0]       pack_cnt;
   logic [WW-1:0]       wcnt;
   logic                pack_full, xfer, last_word;

   assign issue_v = (state_q == ISSUE);
   assign busy    = (state_q != IDLE);

   // Capture strobe and entry slot follow the issued address by LUT_LATENCY cycles.
   generate
      if (LUT_LATENCY == 0) begin : g_comb
         assign cap_v = issue_v;
         assign cap_k = slot_q;
      end else begin : g_pipe
         logic [LUT_LATENCY-1:0] v_q;
         logic [KW-1:0]          k_q [LUT_LATENCY];
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) v_q <= '0;
            else      v_q <= {v_q[LUT_LATENCY-1:0], issue_v} >> 0;
         end
         // NOTE: the slot stages carry no reset; they are only looked at when v_q says so.
         always_ff @(posedge clk) begin
            k_q[0] <= slot_q;
            for (int i = 1; i < LUT_LATENCY; i++) k_q[i] <= k_q[i-1];
         end
         assign cap_v = v_q[LUT_LATENCY-1];
         assign cap_k = k_q[LUT_LATENCY-1];
      end
   endgenerate

   always_comb begin
      pack_word = pack_q;
      for (int k = 0; k < E; k++)
         if (cap_v && cap_k == KW'(k)) pack_word[k*OUT_BITS +: OUT_BITS] = lut_out;
   end

   // A word may complete on the same edge that it moves into the output register.
   assign pack_full = (pack_cnt == CNT_FULL) || (cap_v && pack_cnt == CNT_LAST);
   assign xfer      = pack_full && (!m_valid || m_ready);
   assign last_word = (wcnt == WORD_LAST);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path infers a latch.
      state_d  = state_q;
      slot_d   = slot_q;
      lut_in_d = lut_in;
      done_d   = 1'b0;
      clear    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = ISSUE;
               clear    = 1'b1;
               slot_d   = '0;
               lut_in_d = '0;
            end
         end
         ISSUE: begin
            if (slot_q == SLOT_LAST) begin
               slot_d = '0;
               if (!xfer)          state_d  = WAIT;
               else if (last_word) state_d  = FINISH;
               else                lut_in_d = lut_in + IN_BITS'(1);
            end else begin
               slot_d   = slot_q + KW'(1);
               lut_in_d = lut_in + IN_BITS'(1);
            end
         end
         WAIT: begin
            if (xfer) begin
               if (last_word) state_d = FINISH;
               else begin
                  state_d  = ISSUE;
                  lut_in_d = lut_in + IN_BITS'(1);
               end
            end
         end
         FINISH: begin
            if (m_valid && m_ready) begin
               state_d  = IDLE;
               done_d   = 1'b1;
               lut_in_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         slot_q   <= '0;
         lut_in   <= '0;
         done     <= 1'b0;
         pack_q   <= '0;
         pack_cnt <= '0;
         wcnt     <= '0;
         sum      <= '0;
         m_valid  <= 1'b0;
         m_data   <= '0;
         m_last   <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register sees pre-edge values.
         state_q <= state_d;
         slot_q  <= slot_d;
         lut_in  <= lut_in_d;
         done    <= done_d;
         if (clear) begin
            pack_q   <= '0;
            pack_cnt <= '0;
            wcnt     <= '0;
            sum      <= '0;
         end else begin
            if (cap_v) sum <= sum + 16'(lut_out);
            if (xfer) begin
               pack_cnt <= '0;
               wcnt     <= wcnt + WW'(1);
            end else if (cap_v) begin
               pack_cnt <= pack_cnt + CW'(1);
               pack_q   <= pack_word;
            end
         end
         if (xfer) begin
            m_valid <= 1'b1;
            m_data  <= pack_word;
            m_last  <= last_word;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_lut_table_dump.sv
// Scoreboard bench for lut_table_dump: a table-driven neuron model feeds the DUT,
// expected words are queued at start, and a monitor compares every presented word.
module tb_lut_table_dump;
   localparam int E  = 16;
   localparam int NW = 16;
   localparam int N  = 256;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int fails  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Main DUT, combinational neuron
   logic        start = 1'b0;
   logic        busy, done, m_valid, m_last;
   logic        m_ready = 1'b1;
   logic [7:0]  lut_in;
   logic [1:0]  lut_out;
   logic [31:0] m_data;
   logic [15:0] sum;
   logic [1:0]  tbl [N];
   assign lut_out = tbl[lut_in];

   lut_table_dump u_dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .lut_in(lut_in), .lut_out(lut_out),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .sum(sum)
   );

   // Second DUT with a two-cycle neuron computing lut_in[1:0]
   logic        start2 = 1'b0;
   logic        busy2, done2, m_valid2, m_last2, m_ready2;
   logic [7:0]  lut_in2;
   logic [1:0]  lut_out2, p1, p2;
   logic [31:0] m_data2;
   logic [15:0] sum2;
   assign m_ready2 = 1'b1;
   always @(posedge clk) begin
      p1 <= lut_in2[1:0];
      p2 <= p1;
   end
   assign lut_out2 = p2;

   lut_table_dump #(.LUT_LATENCY(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
      .lut_in(lut_in2), .lut_out(lut_out2),
      .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .m_last(m_last2), .sum(sum2)
   );

   // Ready driver: 0 = always ready, 1 = random, 2 = follow rdy_force
   int   rdy_mode  = 0;
   logic rdy_force = 1'b1;
   initial forever begin
      @(posedge clk); #1;
      case (rdy_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = ($urandom_range(0, 3) != 0);
         default: m_ready = rdy_force;
      endcase
   end

   // Scoreboard and monitor for the main DUT
   logic [32:0] exp_q [$];
   logic [15:0] exp_sum = '0;
   int          words_seen = 0;
   int          done_cnt = 0;
   int          done_cyc_q [$];
   int          n0 = 0;

   task automatic push_sweep();
      logic [31:0] w;
      int s;
      s = 0;
      for (int i = 0; i < NW; i++) begin
         w = '0;
         for (int k = 0; k < E; k++) w[2*k +: 2] = tbl[i*E + k];
         exp_q.push_back({(i == NW - 1), w});
      end
      for (int i = 0; i < N; i++) s += int'(tbl[i]);
      exp_sum = 16'(s);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (m_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_word: got %h, want no word", m_data);
            end else begin
               check("m_data", 64'(m_data), 64'(exp_q[0][31:0]));
               check("m_last", 64'(m_last), 64'(exp_q[0][32]));
               if (m_ready) begin
                  void'(exp_q.pop_front());
                  words_seen++;
               end
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc_q.push_back(cyc);
            check("sum_at_done", 64'(sum), 64'(exp_sum));
            check("busy_at_done", 64'(busy), 64'(0));
         end
      end
   end

   // Checker for the two-cycle-latency instance
   logic run2 = 1'b0;
   logic seen_v2 = 1'b0;
   int   n0_2 = 0;
   int   rel2 = 0;
   int   words2 = 0;
   always @(negedge clk) begin
      if (run2) begin
         rel2 = cyc - n0_2;
         if (rel2 >= 1 && rel2 <= 40)
            check("lut_in_L2", 64'(lut_in2),
                  64'(((rel2 - 1) / (E + 2)) * E +
                      ((((rel2 - 1) % (E + 2)) < E) ? ((rel2 - 1) % (E + 2)) : E - 1)));
         if (m_valid2) begin
            if (!seen_v2) check("first_valid_L2", 64'(rel2), 64'(19));
            seen_v2 = 1'b1;
            check("m_data_L2", 64'(m_data2), 64'h0000_0000_E4E4_E4E4);
            check("m_last_L2", 64'(m_last2), 64'(words2 == NW - 1));
            words2++;
         end
         if (done2) begin
            check("sum_L2", 64'(sum2), 64'h0180);
            check("words_L2", 64'(words2), 64'(NW));
            check("busy_L2", 64'(busy2), 64'(0));
            run2 = 1'b0;
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1;
      start = 1'b1;
      n0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int d0;
      int i;
      d0 = done_cnt;
      i = 0;
      while (done_cnt == d0 && i < budget) begin
         @(posedge clk);
         i++;
      end
      if (done_cnt == d0) begin
         checks++;
         fails++;
         $display("FAIL %s: no done within %0d cycles", name, budget);
      end
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"},    64'(busy),    64'(0));
      check({tag, "_done"},    64'(done),    64'(0));
      check({tag, "_lut_in"},  64'(lut_in),  64'(0));
      check({tag, "_m_valid"}, 64'(m_valid), 64'(0));
      check({tag, "_m_data"},  64'(m_data),  64'(0));
      check({tag, "_m_last"},  64'(m_last),  64'(0));
      check({tag, "_sum"},     64'(sum),     64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ws0, k0, i;
      for (int j = 0; j < N; j++) tbl[j] = 2'(j);
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst = 1'b1;

      // Default sweep, both instances started together
      push_sweep();
      @(posedge clk); #1;
      start = 1'b1; start2 = 1'b1;
      n0 = cyc; n0_2 = cyc; run2 = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; start2 = 1'b0;
      wait_done(400, "done_default");
      check("done_cycle", 64'(done_cyc_q[$] - n0), 64'(258));
      check("sum_default", 64'(sum), 64'h0180);
      i = 0;
      while (run2 && i < 400) begin @(posedge clk); i++; end
      check("run2_finished", 64'(run2), 64'(0));

      // Backpressure: m_ready low for 40 cycles from the first m_valid
      rdy_mode = 2; rdy_force = 1'b0;
      push_sweep();
      pulse_start();
      i = 0;
      while (!m_valid && i < 100) begin @(negedge clk); i++; end
      check("first_valid_cycle", 64'(cyc - n0), 64'(17));
      repeat (35) @(negedge clk);
      check("lut_in_stall", 64'(lut_in), 64'(31));
      check("stall_data", 64'(m_data), 64'h0000_0000_E4E4_E4E4);
      repeat (4) @(negedge clk);
      rdy_force = 1'b1;
      wait_done(600, "done_backpressure");
      check("queue_empty_bp", 64'(exp_q.size()), 64'(0));

      // Constant-3 neuron under random backpressure
      rdy_mode = 1;
      for (int j = 0; j < N; j++) tbl[j] = 2'b11;
      push_sweep();
      pulse_start();
      wait_done(2000, "done_const3");
      check("sum_const3", 64'(sum), 64'h0300);
      check("queue_empty_c3", 64'(exp_q.size()), 64'(0));

      // Random tables under random backpressure
      for (int r = 0; r < 2; r++) begin
         for (int j = 0; j < N; j++) tbl[j] = 2'($urandom);
         push_sweep();
         pulse_start();
         wait_done(2000, "done_random");
         check("queue_empty_rnd", 64'(exp_q.size()), 64'(0));
      end

      // Reset during word 7, then a fresh sweep
      rdy_mode = 0;
      for (int j = 0; j < N; j++) tbl[j] = 2'(j);
      push_sweep();
      pulse_start();
      ws0 = words_seen;
      i = 0;
      while (words_seen < ws0 + 7 && i < 500) begin @(posedge clk); i++; end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_reset_values("midreset");
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      push_sweep();
      pulse_start();
      wait_done(400, "done_after_reset");
      check("sum_after_reset", 64'(sum), 64'h0180);
      check("queue_empty_rst", 64'(exp_q.size()), 64'(0));

      // start pulsed while busy is ignored
      k0 = done_cnt;
      push_sweep();
      pulse_start();
      repeat (50) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(400, "done_busy_pulse");
      repeat (10) @(posedge clk);
      #1;
      check("busy_after_pulse", 64'(busy), 64'(0));
      check("done_count_pulse", 64'(done_cnt - k0), 64'(1));
      check("queue_empty_pulse", 64'(exp_q.size()), 64'(0));

      // start held high for 600 cycles: back-to-back sweeps
      push_sweep(); push_sweep(); push_sweep();
      k0 = done_cyc_q.size();
      @(posedge clk); #1;
      start = 1'b1;
      n0 = cyc;
      repeat (600) @(posedge clk);
      #1;
      start = 1'b0;
      check("held_done_count", 64'(done_cyc_q.size() - k0), 64'(2));
      if (done_cyc_q.size() >= k0 + 2) begin
         check("held_done1_cycle", 64'(done_cyc_q[k0] - n0), 64'(258));
         check("held_done2_cycle", 64'(done_cyc_q[k0+1] - n0), 64'(516));
      end
      wait_done(400, "done_held_third");
      check("queue_empty_held", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
